// File: rtl/core_pc_selector.sv
// Front-end fetch PC selector: sequential advance, commit-time redirect, control-flow FSM.
// Optional perf counters enabled by defining CORE_PC_SEL_PERF_EN.
module core_pc_selector #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned     INSTR_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_start,
    input  logic            cmd_halt,
    input  logic            cmd_flush_done,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_target,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc_addr,
    input  logic            pc_ready,
    output logic            st_busy,
    output logic [1:0]      st_state,
`ifdef CORE_PC_SEL_PERF_EN
    output logic [31:0]     perf_redir_cnt,
    output logic [31:0]     perf_stall_cnt,
`endif
    output logic            redir_misalign
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    // Masking instead of slicing keeps INSTR_BYTES == 1 legal (zero alignment bits).
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic            transfer;
    logic            redir_take;

    assign pc_valid       = (state_q == ST_RUN);
    assign pc_addr        = pc_q;
    assign st_state       = state_q;
    assign st_busy        = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign redir_misalign = misalign_q;

    assign transfer   = pc_valid && pc_ready;
    assign redir_take = redir_valid && (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        if (redir_take) begin
            pc_d       = redir_target & ~ALIGN_MASK;
            misalign_d = |(redir_target & ALIGN_MASK);
            state_d    = ST_FLUSH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_start) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (cmd_halt) begin
                        state_d = ST_HALTED;
                    end else if (transfer) begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
                ST_FLUSH: begin
                    if (cmd_flush_done) state_d = ST_RUN;
                end
                ST_HALTED: begin
                    if (cmd_start) state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef CORE_PC_SEL_PERF_EN
    logic [31:0] redir_cnt_q, redir_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        redir_cnt_d = redir_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (redir_take && (redir_cnt_q != '1)) redir_cnt_d = redir_cnt_q + 32'd1;
        if (pc_valid && !pc_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redir_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            redir_cnt_q <= redir_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_redir_cnt = redir_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_core_pc_selector.sv
// Directed vector bench for core_pc_selector; perf checks when CORE_PC_SEL_PERF_EN is defined.
module tb_core_pc_selector;

    logic        clk;
    logic        rst;
    logic        cmd_start;
    logic        cmd_halt;
    logic        cmd_flush_done;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        pc_valid;
    logic [31:0] pc_addr;
    logic        pc_ready;
    logic        st_busy;
    logic [1:0]  st_state;
    logic        redir_misalign;
`ifdef CORE_PC_SEL_PERF_EN
    logic [31:0] perf_redir_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks;
    int errors;

    core_pc_selector #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .INSTR_BYTES(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_start     (cmd_start),
        .cmd_halt      (cmd_halt),
        .cmd_flush_done(cmd_flush_done),
        .redir_valid   (redir_valid),
        .redir_target  (redir_target),
        .pc_valid      (pc_valid),
        .pc_addr       (pc_addr),
        .pc_ready      (pc_ready),
        .st_busy       (st_busy),
        .st_state      (st_state),
`ifdef CORE_PC_SEL_PERF_EN
        .perf_redir_cnt(perf_redir_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .redir_misalign(redir_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic        halt;
        logic        fdone;
        logic        rv;
        logic [31:0] rt;
        logic        ready;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [1:0]  e_state;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic s, logic h, logic f, logic v, logic [31:0] t,
                                logic rd, logic ev, logic [31:0] ea, logic [1:0] es, logic em);
        vec_t x;
        x.rst = r; x.start = s; x.halt = h; x.fdone = f; x.rv = v; x.rt = t; x.ready = rd;
        x.e_valid = ev; x.e_addr = ea; x.e_state = es; x.e_mis = em;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic h, input logic f,
                         input logic v, input logic [31:0] t, input logic rd);
        @(negedge clk);
        rst = r; cmd_start = s; cmd_halt = h; cmd_flush_done = f;
        redir_valid = v; redir_target = t; pc_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [31:0] ea,
                             input logic [1:0] es, input logic em);
        check({tag, ".valid"}, 32'(pc_valid), 32'(ev));
        check({tag, ".addr"}, pc_addr, ea);
        check({tag, ".state"}, 32'(st_state), 32'(es));
        check({tag, ".busy"}, 32'(st_busy), 32'((es == 2'd1) || (es == 2'd2)));
        check({tag, ".mis"}, 32'(redir_misalign), 32'(em));
    endtask

    initial begin
        int cyc;
        checks = 0;
        errors = 0;
        rst = 1'b0; cmd_start = 1'b0; cmd_halt = 1'b0; cmd_flush_done = 1'b0;
        redir_valid = 1'b0; redir_target = '0; pc_ready = 1'b0;

        //            rst s  h  fd rv target        rdy  valid addr          st   mis
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0,  0, 32'h0000_0000, 2'd0, 0)); // reset
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h500,      0,  0, 32'h0000_0000, 2'd0, 0)); // redirect ignored in IDLE
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0,  1, 32'h0000_0000, 2'd1, 0)); // start
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1,  1, 32'h0000_0004, 2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1,  1, 32'h0000_0008, 2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1,  1, 32'h0000_000C, 2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1,  1, 32'h0000_0010, 2'd1, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,    0,  1, 32'h0000_0010, 2'd1, 0)); // stall holds
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1,  1, 32'h0000_0014, 2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1,  1, 32'h0000_0018, 2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1,  1, 32'h0000_001C, 2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1,  1, 32'h0000_0020, 2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h1002,     1,  0, 32'h0000_1000, 2'd2, 1)); // redirect + transfer
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0,  0, 32'h0000_1000, 2'd2, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,        0,  1, 32'h0000_1000, 2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1,  1, 32'h0000_1004, 2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h100,      0,  0, 32'h0000_0100, 2'd2, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,        0,  0, 32'h0000_0100, 2'd2, 0)); // halt ignored in FLUSH
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h200,      0,  0, 32'h0000_0200, 2'd2, 0)); // latest target wins
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h303,      0,  0, 32'h0000_0300, 2'd2, 1)); // flush_done + redirect
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,        0,  1, 32'h0000_0300, 2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h40,       0,  0, 32'h0000_0040, 2'd2, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,        0,  1, 32'h0000_0040, 2'd1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,        0,  0, 32'h0000_0040, 2'd3, 0)); // halt
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1,  0, 32'h0000_0040, 2'd3, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0,  1, 32'h0000_0040, 2'd1, 0)); // resume
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,        0,  0, 32'h0000_0040, 2'd3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h888,      0,  0, 32'h0000_0000, 2'd0, 0)); // rst over redirect
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0,  1, 32'h0000_0000, 2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'hFFFF_FFFC,0,  0, 32'hFFFF_FFFC, 2'd2, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,        0,  1, 32'hFFFF_FFFC, 2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1,  1, 32'h0000_0000, 2'd1, 0)); // wrap, no flag
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h81,       1,  0, 32'h0000_0080, 2'd2, 1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h0,        0,  0, 32'h0000_0000, 2'd0, 0)); // rst mid-FLUSH

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].halt, vecs[i].fdone,
                  vecs[i].rv, vecs[i].rt, vecs[i].ready);
            check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_addr,
                      vecs[i].e_state, vecs[i].e_mis);
        end

        // Redirect-to-valid latency with flush_done one cycle after the redirect.
        drive(0, 1, 0, 0, 0, 32'h0, 0);
        drive(0, 0, 0, 0, 1, 32'h0000_2000, 0);
        cyc = 1;
        drive(0, 0, 0, 1, 0, 32'h0, 0);
        cyc++;
        while (!pc_valid && cyc < 10) begin
            drive(0, 0, 0, 0, 0, 32'h0, 0);
            cyc++;
        end
        check("latency", 32'(cyc), 32'd2);
        check("latency.addr", pc_addr, 32'h0000_2000);

`ifdef CORE_PC_SEL_PERF_EN
        drive(1, 0, 0, 0, 0, 32'h0, 0);
        check("perf.redir_rst", perf_redir_cnt, 32'd0);
        check("perf.stall_rst", perf_stall_cnt, 32'd0);
        drive(0, 0, 0, 0, 1, 32'h10, 0);  // ignored in IDLE, not counted
        drive(0, 1, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 32'h0, 0);
        drive(0, 0, 0, 0, 0, 32'h0, 1);
        check("perf.stall5", perf_stall_cnt, 32'd5);
        drive(0, 0, 0, 0, 1, 32'h300, 0);
        drive(0, 0, 0, 0, 1, 32'h400, 0);
        check("perf.redir2", perf_redir_cnt, 32'd2);
        check("perf.stall_hold", perf_stall_cnt, 32'd6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_pc_selector.md
Name: core_pc_selector

Overview:
- Front-end PC generation stage, directly upstream of the instruction page walker. Produces the selected_pc stream that the page walker and instruction loader consume.
- Holds the architectural fetch PC, advances it sequentially on each accepted fetch, and redirects on commit-time mispredict or exception.
- Runs under the core control flow: start, halt and flush_done come from control flow; busy and state go back to it.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_PC, 32'h0000_0000, first fetch address after start from reset.
- INSTR_BYTES, 4, sequential PC increment; power of two; alignment = log2(INSTR_BYTES) low bits.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- cmd_start  in  1  control flow: begin or resume fetching.
- cmd_halt  in  1  control flow: stop issuing PCs, keep PC.
- cmd_flush_done  in  1  control flow: pipeline flush complete after redirect.
- redir_valid  in  1  commit broadcast: redirect request.
- redir_target  in  XLEN  commit broadcast: redirect PC.
- pc_valid  out  1  selected_pc valid to page walker.
- pc_addr  out  XLEN  selected_pc address.
- pc_ready  in  1  page walker accepts pc_addr this cycle.
- st_busy  out  1  high in RUN and FLUSH.
- st_state  out  2  current state encoding.
- redir_misalign  out  1  one-cycle pulse: redirect target was misaligned.

Behaviour:
- Reset: all of the following take effect on the next rising clk after rst=1, and rst overrides every other input, including mid-handshake and mid-FLUSH.
  - state=IDLE (2'd0), pc_addr=RESET_PC, pc_valid=0, st_busy=0, redir_misalign=0.
- States (encoding):
  - IDLE (0): pc_valid=0. cmd_start moves to RUN and keeps pc_addr unchanged.
  - RUN (1): pc_valid=1. Transfer occurs when pc_valid&&pc_ready; on a transfer, pc_addr <= pc_addr+INSTR_BYTES next cycle. pc_addr is stable while pc_valid&&!pc_ready.
  - FLUSH (2): pc_valid=0. Waits for cmd_flush_done, then moves to RUN; the redirect target is presented the following cycle.
  - HALTED (3): pc_valid=0, pc_addr held. cmd_start moves to RUN.
- Redirect:
  - redir_valid in any non-IDLE state: pc_addr <= {redir_target[XLEN-1:A],A'b0}, where A=log2(INSTR_BYTES); then state <= FLUSH.
  - redir_misalign pulses 1 cycle if redir_target low A bits are nonzero.
  - redir_valid in IDLE is ignored.
- Priorities, same cycle: rst > redir_valid > cmd_halt > cmd_start > transfer increment.
  - A transfer in the same cycle as a redirect still completes on the interface, but the increment is discarded and the redirect target wins.
- Redirect during FLUSH overwrites the pending target (latest wins) and stays in FLUSH.
- cmd_flush_done together with a redirect: stay in FLUSH with the new target.
- cmd_halt in RUN moves to HALTED. cmd_halt in FLUSH is ignored.
- Wrap-around: pc_addr+INSTR_BYTES is modulo 2^XLEN; no flag is raised.
- Latency: redirect to first new pc_valid = 2 cycles when cmd_flush_done is asserted in the cycle after the redirect.
- st_busy = (state==RUN)||(state==FLUSH).

Optional Feature:
- Macro CORE_PC_SEL_PERF_EN.
- Defined: adds outputs perf_redir_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_redir_cnt increments on each accepted redirect (not in IDLE).
  - perf_stall_cnt increments each cycle with pc_valid&&!pc_ready.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then cmd_start=1 for 1 cycle, pc_ready=1 for 3 cycles -> pc_addr sequence 0x0, 0x4, 0x8; pc_valid=1 from the cycle after start.
- RUN at 0x10 with pc_ready=0 for 5 cycles -> pc_addr holds 0x10 and pc_valid=1 throughout; with PERF_EN, perf_stall_cnt=5.
- RUN at 0x20, redir_valid=1 and target=0x1002 in the same cycle as a transfer -> state FLUSH, pc_valid=0, redir_misalign pulses; after cmd_flush_done, pc_addr=0x1000 with pc_valid=1.
- FLUSH with target 0x100, second redirect to 0x200, then cmd_flush_done -> first PC presented is 0x200.
- XLEN=32 at pc_addr=0xFFFF_FFFC, one transfer -> pc_addr=0x0, no flag.
- RUN at 0x40, cmd_halt -> HALTED with pc_addr held at 0x40; then rst=1 -> IDLE with pc_addr=RESET_PC and pc_valid=0.
